mux_scan_sequencer: RTL
=======================

# mux_scan_sequencer

Sequencer directly upstream of the 8:1 select mux (`mux8x1`). It accepts an 8-bit word through a valid/ready handshake and holds it on the mux data inputs. It then steps the 3-bit select lines through all eight positions, one slot per DIVIDE clocks, so the mux output becomes a serial bitstream. Frame markers and back-to-back loading allow gapless streaming.

## Interface
- DIVIDE, 1: clocks per bit slot; legal range 1..256.
- MSB_FIRST, 0: 0 = select order 0→7; 1 = select order 7→0.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_data  input  8  word to serialise.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  sequencer accepts a word this cycle.
- d  output  8  latched word; bit k drives mux input ik.
- s0, s1, s2  output  1 each  mux select, s2 = MSB.
- bit_valid  output  1  current select slot carries frame data.
- frame_start  output  1  first cycle of slot 0 of a frame.
- frame_end  output  1  last cycle of final slot of a frame.
- hold  input  1  present only with MUX_SCAN_HOLD_EN; freezes sequencing.

## Operation
- Reset values while rst is high: state IDLE, d=0, {s2,s1,s0}=0, bit_valid=0, frame_start=0, frame_end=0, load_ready=0. Handshakes are ignored.
- State IDLE:
  - load_ready=1.
  - On load_valid&&load_ready: latch d←load_data, idx←0, tick←0, go to RUN.
- State RUN:
  - bit_valid=1.
  - Select = idx when MSB_FIRST=0; select = 7−idx when MSB_FIRST=1.
  - tick counts 0..DIVIDE−1.
  - At tick=DIVIDE−1: tick←0, idx←idx+1 (3-bit; the wrap 7→0 ends the frame).
- Last cycle of frame (idx=7, tick=DIVIDE−1):
  - frame_end=1 and load_ready=1.
  - If load_valid=1: the new word is latched and RUN continues with idx=0 next cycle. frame_start=1 next cycle, no gap.
  - Otherwise: go to IDLE. d keeps its last value, select returns to the first position, bit_valid=0.
- load_ready=0 in RUN except in the last cycle of the frame. load_data is never sampled mid-frame.
- All outputs are registered except load_ready, which is decoded from state/idx/tick and gated by rst.

## Timing
- Acceptance at edge N gives first bit slot visible from cycle N+1. Frame length is exactly 8×DIVIDE cycles.
- DIVIDE=1: select changes every cycle; back-to-back frames have period 8 cycles.
- frame_start and frame_end are each high for exactly one cycle. With DIVIDE=1 they fall in different cycles (slot 0 vs slot 7).
- Reset asserted mid-frame: the next cycle shows the reset values. The frame is discarded, with no partial frame_end.
- load_valid may drop without acceptance; there is no stickiness requirement.

## Configuration
- MUX_SCAN_HOLD_EN defined:
  - The `hold` port exists.
  - When hold=1 in RUN, tick, idx and select freeze. bit_valid stays 1, but frame_start/frame_end/load_ready are forced 0 for that cycle.
  - hold in IDLE does not block loading.
- Macro undefined: no `hold` port; sequencing is never stalled.

## Structure
- Shared package `mux_scan_pkg`:
  - state enum {IDLE, RUN}
  - localparam NUM_SLOTS=8
  - IDX_W=3
- Single module; no sub-module needed.
- The downstream mux8x1 is instantiated only in the bench to check the serial output.

## Test plan
- Reset, DIVIDE=1, MSB_FIRST=0: load 8'hA5 at cycle 0 → mux output 1,0,1,0,0,1,0,1 on cycles 1..8; frame_start at cycle 1, frame_end at cycle 8, IDLE at cycle 9.
- MSB_FIRST=1, load 8'h01 → select 7,6,…,0; mux output 0 for seven slots, then 1 in the final slot.
- DIVIDE=3, load 8'hF0 → each select value held 3 cycles; frame is 24 cycles; frame_end only on cycle 24.
- Back-to-back, DIVIDE=1: load_valid held with 8'h0F then 8'hFF → second acceptance on frame_end cycle 8; frame_start cycle 9; no bit_valid gap.
- Reset asserted at cycle 4 of a frame → next cycle bit_valid=0, select=0, d=0; no frame_end; load_ready=1 after reset release.
- MUX_SCAN_HOLD_EN: hold=1 for 5 cycles at idx=3 → select stays 3; frame completes 5 cycles late; frame_end appears once.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan sequencer.
//   state_t   : sequencer state (IDLE waiting for a word, RUN scanning slots)
//   NUM_SLOTS : number of mux inputs scanned per frame
//   IDX_W     : width of the slot index / mux select
//   slot_sel  : maps a slot index to the select value for the chosen bit order
package mux_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int NUM_SLOTS = 8;
   localparam int IDX_W     = 3;

   // Slot 0 is always the first slot of a frame; with msb_first the scan
   // starts at input 7 and walks down.
   function automatic logic [IDX_W-1:0] slot_sel(input logic [IDX_W-1:0] idx,
                                                 input logic            msb_first);
      return msb_first ? (IDX_W'(NUM_SLOTS - 1) - idx) : idx;
   endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: load handshake plus mux-facing outputs.
//   load_data/load_valid/load_ready : word handshake into the sequencer
//   d                               : latched word, bit k feeds mux input ik
//   s0/s1/s2                        : mux select (s2 = MSB)
//   bit_valid/frame_start/frame_end : frame qualifiers
// modport slave  : the sequencer side
// modport master : the word producer / observer side
interface mux_scan_sequencer_if;
   logic [7:0] load_data;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] d;
   logic       s0;
   logic       s1;
   logic       s2;
   logic       bit_valid;
   logic       frame_start;
   logic       frame_end;

   modport slave (
      input  load_data, load_valid,
      output load_ready, d, s0, s1, s2, bit_valid, frame_start, frame_end
   );

   modport master (
      output load_data, load_valid,
      input  load_ready, d, s0, s1, s2, bit_valid, frame_start, frame_end
   );
endinterface

// File: rtl/mux8x1.sv
// mux8x1: plain 8:1 select mux fed by the scan sequencer.
//   i0..i7   : data inputs
//   s0/s1/s2 : select, s2 = MSB
//   y        : selected input
module mux8x1 (
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   input  logic i4,
   input  logic i5,
   input  logic i6,
   input  logic i7,
   input  logic s0,
   input  logic s1,
   input  logic s2,
   output logic y
);
   logic [7:0] in_vec;

   assign in_vec = {i7, i6, i5, i4, i3, i2, i1, i0};
   assign y      = in_vec[{s2, s1, s0}];
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: accepts an 8-bit word and steps the 8:1 mux select
// through all eight positions, DIVIDE clocks per slot, turning the word into
// a serial bitstream at the mux output. A word offered during the last cycle
// of a frame is taken without a gap.
// Parameters:
//   DIVIDE    : clocks per bit slot (1..256)
//   MSB_FIRST : 0 = select 0..7, 1 = select 7..0
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mux_scan_sequencer_if.slave (handshake + mux-facing outputs)
//   hold : only when MUX_SCAN_HOLD_EN is defined; freezes sequencing in RUN
// All bus outputs are registered except load_ready, which is decoded from the
// current state and gated by rst.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int DIVIDE    = 1,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic clk,
   input  logic rst,
`ifdef MUX_SCAN_HOLD_EN
   input  logic hold,
`endif
   mux_scan_sequencer_if.slave bus
);

   localparam int                TICK_W    = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIVIDE - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SLOTS - 1);

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [TICK_W-1:0] tick_reg, tick_next;
   logic [7:0]        d_reg, d_next;
   logic [IDX_W-1:0]  sel_reg, sel_next;
   logic              bit_valid_reg, bit_valid_next;
   logic              frame_start_reg, frame_start_next;
   logic              frame_end_reg, frame_end_next;

   logic stall;
   logic slot_last;
   logic frame_last;
   logic load_ready;
   logic fire;

   // hold only matters while a frame is running; an idle sequencer still loads.
`ifdef MUX_SCAN_HOLD_EN
   assign stall = hold && (state_reg == RUN);
`else
   assign stall = 1'b0;
`endif

   assign slot_last  = (tick_reg == TICK_LAST);
   assign frame_last = (state_reg == RUN) && (idx_reg == IDX_LAST) && slot_last;
   assign load_ready = !rst && !stall && ((state_reg == IDLE) || frame_last);
   assign fire       = bus.load_valid && load_ready;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      tick_next  = tick_reg;
      d_next     = d_reg;

      unique case (state_reg)
         IDLE: begin
            if (fire) begin
               d_next     = bus.load_data;
               idx_next   = '0;
               tick_next  = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            if (!stall) begin
               if (slot_last) begin
                  tick_next = '0;
                  // 3-bit wrap from 7 back to 0 closes the frame
                  idx_next  = idx_reg + 1'b1;
               end else begin
                  tick_next = tick_reg + 1'b1;
               end
               if (frame_last) begin
                  if (fire) begin
                     d_next = bus.load_data;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Outputs are registered, so they are derived from the next state.
      // Idle select parks on the first position of the scan order.
      bit_valid_next   = (state_next == RUN);
      sel_next         = slot_sel((state_next == RUN) ? idx_next : '0, MSB_FIRST);
      frame_start_next = (state_next == RUN) && !stall &&
                         (idx_next == '0) && (tick_next == '0);
      frame_end_next   = (state_next == RUN) && !stall &&
                         (idx_next == IDX_LAST) && (tick_next == TICK_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         idx_reg         <= '0;
         tick_reg        <= '0;
         d_reg           <= '0;
         sel_reg         <= '0;
         bit_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_end_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         idx_reg         <= idx_next;
         tick_reg        <= tick_next;
         d_reg           <= d_next;
         sel_reg         <= sel_next;
         bit_valid_reg   <= bit_valid_next;
         frame_start_reg <= frame_start_next;
         frame_end_reg   <= frame_end_next;
      end
   end

   assign bus.load_ready  = load_ready;
   assign bus.d           = d_reg;
   assign bus.s0          = sel_reg[0];
   assign bus.s1          = sel_reg[1];
   assign bus.s2          = sel_reg[2];
   assign bus.bit_valid   = bit_valid_reg;
   assign bus.frame_start = frame_start_reg;
   assign bus.frame_end   = frame_end_reg;

endmodule
